// File: rtl/inst_fetch.sv
// Instruction fetch: word-addressed PC, single-outstanding imem requests and a
// small in-order buffer toward the Decoder. Optional halt-on-opcode: INST_FETCH_HALT_EN.
module inst_fetch #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter int                BUF_DEPTH   = 2,
    parameter logic [2:0]        HALT_OPCODE = 3'b111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, req_pc;
    logic              discard, discard_next;

    logic [31:0]       buf_data [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_next;

    logic req_fire, push, pop, halt_hit, can_fetch, credit_ok;

    assign req_fire = (state == S_REQ) && imem_req_ready;
    // WAIT is the only state with a request in flight; stray responses elsewhere are ignored.
    assign push     = (state == S_WAIT) && imem_rsp_valid && !discard && !redirect_valid;
    assign pop      = inst_valid && inst_ready;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

`ifdef INST_FETCH_HALT_EN
    logic halted_q;

    assign halt_hit = push && (imem_rsp_data[31:29] == HALT_OPCODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halted_q <= 1'b0;
        else if (redirect_valid)
            halted_q <= 1'b0;
        else if (halt_hit)
            halted_q <= 1'b1;
    end

    assign halted = halted_q;
`else
    logic unused_halt_opcode;

    assign unused_halt_opcode = ^HALT_OPCODE;
    assign halt_hit           = 1'b0;
    assign halted             = 1'b0;
`endif

    // Credit is judged on post-edge occupancy, with nothing outstanding after the transition.
    assign credit_ok = count_next < DEPTH;
    assign can_fetch = fetch_en && !halted && !halt_hit;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_next   = state;
        pc_next      = pc;
        discard_next = discard;
        case (state)
            S_IDLE: if (can_fetch && credit_ok) state_next = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    pc_next    = pc + 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    discard_next = 1'b0;
                    state_next   = (can_fetch && credit_ok) ? S_REQ : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (redirect_valid) begin
            pc_next = redirect_pc;
            if (req_fire || (state == S_WAIT && !imem_rsp_valid)) begin
                discard_next = 1'b1;
                state_next   = S_WAIT;
            end else begin
                discard_next = 1'b0;
                state_next   = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            req_pc  <= RESET_PC;
            discard <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            state   <= state_next;
            pc      <= pc_next;
            discard <= discard_next;
            if (req_fire)
                req_pc <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: buffer storage is reset so inst/inst_pc read as zero straight out of reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= imem_rsp_data;
                buf_pc[wr_ptr]   <= req_pc;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (count != '0);
    assign inst           = buf_data[rd_ptr];
    assign inst_pc        = buf_pc[rd_ptr];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: random-latency memory model, queue scoreboard
// of the expected in-order instruction stream, directed scenarios plus a random phase.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic        halted;

    inst_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] data;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    // memory model controls and observation
    int          lat          = 1;
    int          ready_pct    = 100;
    bit          hold_ready   = 1'b0;
    bit          halt_word_en = 1'b0;
    logic [15:0] fire_log[$];

    // scoreboard state
    exp_t        sb[$];
    logic [15:0] sb_next_pc;
    int          accepted     = 0;
    int          seg_count    = 0;
    logic [15:0] seg_first_pc = '0;
    logic [15:0] last_pc      = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [15:0] a);
        if (halt_word_en && a == 16'h0002)
            return 32'hE0FC3FFF;
        return {3'b010, a[12:0], a};
    endfunction

    function automatic void sb_fill();
        while (sb.size() < 8) begin
            sb.push_back('{pc: sb_next_pc, data: mem_fn(sb_next_pc)});
            sb_next_pc = sb_next_pc + 16'd1;
        end
    endfunction

    function automatic void sb_restart(input logic [15:0] start_pc);
        sb.delete();
        sb_next_pc = start_pc;
        seg_count  = 0;
        sb_fill();
    endfunction

    // Monitor: decoder-side handshakes compared with the expected stream.
    initial begin
        exp_t e;
        sb_restart(16'h0000);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_restart(16'h0000);
            end else begin
                if (inst_valid && inst_ready) begin
                    if (sb.size() == 0) sb_fill();
                    e = sb.pop_front();
                    check("inst_pc", inst_pc, e.pc);
                    check("inst", inst, e.data);
                    if (seg_count == 0) seg_first_pc = inst_pc;
                    accepted++;
                    seg_count++;
                    last_pc = inst_pc;
                    sb_fill();
                end
                if (redirect_valid) sb_restart(redirect_pc);
            end
        end
    end

    // Memory model: random ready, in-order response after 'lat' edges, protocol checks.
    initial begin
        bit          fire_seen  = 1'b0;
        bit          stall_prev = 1'b0;
        bit          pending    = 1'b0;
        logic [15:0] fire_addr  = '0;
        logic [15:0] stall_addr = '0;
        logic [15:0] pend_addr  = '0;
        int          pend_cnt   = 0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (fire_seen) begin
                check("one_outstanding", 32'(pending), 32'd0);
                pending   = 1'b1;
                pend_addr = fire_addr;
                pend_cnt  = lat;
            end
            if (pending) begin
                if (pend_cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_fn(pend_addr);
                    pending        = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            imem_req_ready = !hold_ready && ($urandom_range(99) < ready_pct);
            @(negedge clk);
            if (stall_prev && rst_n) begin
                check("req_hold_valid", 32'(imem_req_valid), 32'd1);
                check("req_hold_addr", 32'(imem_req_addr), 32'(stall_addr));
            end
            fire_seen  = rst_n && imem_req_valid && imem_req_ready;
            fire_addr  = imem_req_addr;
            if (fire_seen) fire_log.push_back(imem_req_addr);
            stall_prev = rst_n && imem_req_valid && !imem_req_ready && !redirect_valid;
            stall_addr = imem_req_addr;
        end
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [15:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        fire_log.delete();
        cycle(1);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_fires(input string name, input int n, input int budget);
        int k = 0;
        while (fire_log.size() < n && k < budget) begin
            cycle(1);
            k++;
        end
        check({name, "_timeout"}, 32'(fire_log.size() >= n), 32'd1);
    endtask

    task automatic wait_seg(input string name, input int n, input int budget);
        int k = 0;
        while (seg_count < n && k < budget) begin
            cycle(1);
            k++;
        end
        check({name, "_timeout"}, 32'(seg_count >= n), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          prev;
        int          k;
        logic [15:0] ahead;

        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;
        #2;
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", 32'(inst_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_req_addr", 32'(imem_req_addr), 32'h0000);
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        end

        // sequential fetch, 1-cycle memory
        fire_log.delete();
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        wait_seg("seq", 4, 60);
        check("seq_first_addr", 32'(fire_log.size() > 0 ? fire_log[0] : 16'hDEAD), 32'h0000);
        check("seq_first_pc", 32'(seg_first_pc), 32'h0000);

        // backpressure: buffer fills to BUF_DEPTH then requests stop
        inst_ready = 1'b0;
        cycle(10);
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_inst_valid", 32'(inst_valid), 32'd1);
        ahead = fire_log[$] + 16'd1 - sb[0].pc;
        check("bp_buffered", 32'(ahead), 32'd2);
        prev       = accepted;
        inst_ready = 1'b1;
        cycle(20);
        check("bp_resume", 32'(accepted - prev >= 8), 32'd1);

        // redirect while the request to 0x0005 is outstanding
        lat = 4;
        do_redirect(16'h0003);
        k = 0;
        while (!(fire_log.size() > 0 && fire_log[$] == 16'h0005) && k < 100) begin
            cycle(1);
            k++;
        end
        check("rd_saw_0005", 32'(k < 100), 32'd1);
        do_redirect(16'h0100);
        wait_fires("rd_fire", 1, 100);
        check("rd_next_addr", 32'(fire_log.size() > 0 ? fire_log[0] : 16'hDEAD), 32'h0100);
        wait_seg("rd_seg", 1, 100);
        check("rd_next_inst_pc", 32'(seg_first_pc), 32'h0100);

        // PC wrap
        lat = 2;
        do_redirect(16'hFFFF);
        wait_fires("wrap_fire", 2, 100);
        check("wrap_addr0", 32'(fire_log.size() > 0 ? fire_log[0] : 16'hDEAD), 32'hFFFF);
        check("wrap_addr1", 32'(fire_log.size() > 1 ? fire_log[1] : 16'hDEAD), 32'h0000);
        wait_seg("wrap_seg", 2, 100);

        // async reset between edges while a request is outstanding
        lat = 6;
        fire_log.delete();
        wait_fires("arst_fire", 1, 100);
        #2;
        rst_n      = 1'b0;
        hold_ready = 1'b1;
        #1;
        check("arst_req_valid", 32'(imem_req_valid), 32'd0);
        check("arst_req_addr", 32'(imem_req_addr), 32'h0000);
        check("arst_inst_valid", 32'(inst_valid), 32'd0);
        check("arst_inst_pc", 32'(inst_pc), 32'd0);
        cycle(2);
        rst_n = 1'b1;
        fire_log.delete();
        cycle(6);
        check("arst_late_ignored", 32'(inst_valid), 32'd0);
        hold_ready = 1'b0;
        lat        = 1;
        wait_fires("arst_restart", 1, 50);
        check("arst_restart_addr", 32'(fire_log.size() > 0 ? fire_log[0] : 16'hDEAD), 32'h0000);
        wait_seg("arst_seg", 2, 50);
        check("arst_first_pc", 32'(seg_first_pc), 32'h0000);

        // random phase
        prev      = accepted;
        ready_pct = 75;
        for (int i = 0; i < 1500; i++) begin
            fetch_en   = ($urandom_range(7) != 0);
            inst_ready = ($urandom_range(3) != 0);
            lat        = $urandom_range(4, 1);
            if ($urandom_range(39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 16'($urandom);
            end else begin
                redirect_valid = 1'b0;
            end
            cycle(1);
        end
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        inst_ready     = 1'b1;
        ready_pct      = 100;
        lat            = 1;
        cycle(20);
        check("rand_progress", 32'(accepted - prev > 100), 32'd1);

        // halt opcode at 0x0002
        halt_word_en = 1'b1;
        do_redirect(16'h0000);
        cycle(30);
`ifdef INST_FETCH_HALT_EN
        check("halt_set", 32'(halted), 32'd1);
        check("halt_fire_count", 32'(fire_log.size()), 32'd3);
        check("halt_last_addr", 32'(fire_log.size() > 0 ? fire_log[$] : 16'hDEAD), 32'h0002);
        check("halt_drained", 32'(seg_count), 32'd3);
        check("halt_last_pc", 32'(last_pc), 32'h0002);
        do_redirect(16'h0010);
        check("halt_cleared", 32'(halted), 32'd0);
        wait_fires("halt_resume", 1, 50);
        check("halt_resume_addr", 32'(fire_log.size() > 0 ? fire_log[0] : 16'hDEAD), 32'h0010);
`else
        check("nohalt_flag", 32'(halted), 32'd0);
        check("nohalt_continues", 32'(fire_log.size() > 3), 32'd1);
        check("nohalt_drained", 32'(seg_count > 3), 32'd1);
`endif
        halt_word_en = 1'b0;
        do_redirect(16'h0040);
        wait_seg("final_seg", 3, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
